du_exec_skid_reg_way1: RTL

//  Way-1 pipeline register between the decoder and the EU. Holds the decoded bundle
//  (rd, operands, imm, opcode fields, shamt, pID) in a 2-entry skid buffer.
//  All outputs are registered; full throughput under valid/ready; synchronous flush.

---
 rtl/du_exec_skid_reg_way1_pkg.sv | 34 +++
 rtl/du_exec_skid_reg_way1_slot.sv | 27 ++
 rtl/du_exec_skid_reg_way1.sv | 130 +++++++++++++
 3 files changed

// File: rtl/du_exec_skid_reg_way1_pkg.sv
// Shared definitions for the way-1 decode/execute skid register.
// The optional trace payload is enabled with DU_TRACE_EN.
package du_exec_skid_reg_way1_pkg;

  localparam int unsigned DU_XLEN  = 64;
  localparam int unsigned DU_PID_W = 2;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

`ifdef DU_TRACE_EN
  localparam int unsigned DU_TRACE_W = 32;
`else
  localparam int unsigned DU_TRACE_W = 0;
`endif

  function automatic int unsigned du_bundle_w(input int unsigned xlen,
                                              input int unsigned pid_w);
    return 5 + 1 + 3 * xlen + 7 + 3 + 7 + 6 + pid_w + DU_TRACE_W;
  endfunction

  // Encoded as {main_valid, skid_valid}
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    ILLEGAL = 2'b01,
    ONE     = 2'b10,
    TWO     = 2'b11
  } skid_state_t;

endpackage

// File: rtl/du_exec_skid_reg_way1_slot.sv
// One skid-buffer slot: valid bit plus payload register with load/clear.
// Clear beats load so a flush always empties the slot.
module du_skid_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/du_exec_skid_reg_way1.sv
// Way-1 decoder->EU pipeline register: 2-entry skid buffer, registered outputs.
// Define DU_TRACE_EN to add instAddr payload and the stallCnt_o counter.
module du_exec_skid_reg_way1
  import du_exec_skid_reg_way1_pkg::*;
#(
  parameter int unsigned XLEN  = DU_XLEN,
  parameter int unsigned PID_W = DU_PID_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [4:0]       rdAddr_i,
  input  logic             rdWriteEnable_i,
  input  logic [XLEN-1:0]  rs1ReadData_i,
  input  logic [XLEN-1:0]  rs2ReadData_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [6:0]       opCode_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic [5:0]       shamt_i,
  input  logic [PID_W-1:0] pID_i,
  output logic [4:0]       rdAddr_o,
  output logic             rdWriteEnable_o,
  output logic [XLEN-1:0]  rs1ReadData_o,
  output logic [XLEN-1:0]  rs2ReadData_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [6:0]       opCode_o,
  output logic [2:0]       funct3_o,
  output logic [6:0]       funct7_o,
  output logic [5:0]       shamt_o,
  output logic [PID_W-1:0] pID_o,
`ifdef DU_TRACE_EN
  input  logic [31:0]      instAddr_i,
  output logic [31:0]      instAddr_o,
  output logic [31:0]      stallCnt_o,
`endif
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int unsigned BW = du_bundle_w(XLEN, PID_W);

  logic [BW-1:0] bundle_in, main_d, main_q, skid_q;
  logic          skid_valid;
  logic          main_load, main_clr, skid_load, skid_clr;
  logic          in_fire, out_fire;
  skid_state_t   state;

  assign bundle_in = {rdAddr_i, rdWriteEnable_i, rs1ReadData_i, rs2ReadData_i, imm_i,
                      opCode_i, funct3_i, funct7_i, shamt_i, pID_i
`ifdef DU_TRACE_EN
                      , instAddr_i
`endif
                      };

  assign {rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o, imm_o,
          opCode_o, funct3_o, funct7_o, shamt_o, pID_o
`ifdef DU_TRACE_EN
          , instAddr_o
`endif
          } = main_q;

  // State lives in the two slot valid bits rather than a separate register
  assign state    = skid_state_t'({valid_o, skid_valid});
  assign ready_o  = ~skid_valid & ~rst;
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;
  assign main_d   = (state == TWO) ? skid_q : bundle_in;

  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush_i) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state)
        EMPTY: main_load = in_fire;
        ONE: begin
          if (in_fire && out_fire) main_load = 1'b1;
          else if (out_fire)       main_clr  = 1'b1;
          else if (in_fire)        skid_load = 1'b1;
        end
        TWO: begin
          main_load = out_fire;
          skid_clr  = out_fire;
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  du_skid_slot #(.W(BW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_d),
    .valid (valid_o),
    .q     (main_q)
  );

  du_skid_slot #(.W(BW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (bundle_in),
    .valid (skid_valid),
    .q     (skid_q)
  );

`ifdef DU_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_o <= '0;
    end else if (valid_o && !ready_i && stallCnt_o != '1) begin
      stallCnt_o <= stallCnt_o + 32'd1;
    end
  end
`endif

endmodule
